// File: rtl/imem_arbiter_if.sv
// Handshake bundle between the IF stage, the program loader, the arbiter and
// the single-port instruction memory. The arbiter drives the memory side (master).
interface imem_arbiter_if #(
    parameter int WIDTH = 32
);
    logic             f_req;
    logic [WIDTH-1:0] f_addr;
    logic             f_flush;
    logic             f_ack;
    logic [31:0]      f_rdata;
    logic             stall_if;

    logic             l_req;
    logic [WIDTH-1:0] l_addr;
    logic [31:0]      l_wdata;
    logic             l_ack;

    logic             mem_req;
    logic             mem_we;
    logic [WIDTH-1:0] mem_addr;
    logic [31:0]      mem_wdata;
    logic             mem_ack;
    logic [31:0]      mem_rdata;

    modport master (
        input  f_req, f_addr, f_flush, l_req, l_addr, l_wdata, mem_ack, mem_rdata,
        output f_ack, f_rdata, stall_if, l_ack, mem_req, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        output f_req, f_addr, f_flush, l_req, l_addr, l_wdata, mem_ack, mem_rdata,
        input  f_ack, f_rdata, stall_if, l_ack, mem_req, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/imem_arbiter.sv
// Round-robin arbiter sharing one instruction-memory port between IF fetches and
// the program loader. Define IMEM_ARB_TIMEOUT_EN to enable the mem_ack watchdog.
module imem_arbiter #(
    parameter int WIDTH   = 32,
    parameter int TIMEOUT = 15
) (
    input  logic           clk,
    input  logic           rst,
    imem_arbiter_if.master bus,
    output logic           err
);
    // state | meaning
    // IDLE  | no memory cycle in flight; arbitrate f_req / l_req
    // FETCH | instruction read in flight for the IF stage
    // LOAD  | loader write in flight
    typedef enum logic [1:0] {IDLE, FETCH, LOAD} state_t;
    typedef enum logic {GNT_FETCH, GNT_LOAD} grant_t;

    localparam logic [31:0] NOP = 32'h0000_0013;

    state_t           state, state_nxt;
    grant_t           last_grant, last_grant_nxt;
    logic             flushed, flushed_nxt;
    logic             mem_req_nxt, mem_we_nxt;
    logic [WIDTH-1:0] mem_addr_nxt;
    logic [31:0]      mem_wdata_nxt;
    logic             f_ack_nxt, l_ack_nxt;
    logic [31:0]      f_rdata_nxt;
    logic             f_cand, l_cand;
    logic             grant_f, grant_l;
    logic             to_hit;

    // A requester whose ack is pulsing this cycle still shows req high; it has
    // not yet presented its next request, so it sits out this arbitration.
    assign f_cand = bus.f_req && !bus.f_flush && !bus.f_ack;
    assign l_cand = bus.l_req && !bus.l_ack;

    assign bus.stall_if = bus.f_req && !bus.f_ack;

`ifdef IMEM_ARB_TIMEOUT_EN
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

    logic [7:0] to_cnt;
    logic       err_q;

    // mem_ack in the terminal cycle wins over the watchdog.
    assign to_hit = (state != IDLE) && !bus.mem_ack && (to_cnt == TO_LAST);
    assign err    = err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            to_cnt <= 8'd0;
            err_q  <= 1'b0;
        end else begin
            if (state == IDLE) begin
                to_cnt <= 8'd0;
            end else if (bus.mem_req) begin
                to_cnt <= to_cnt + 8'd1;
            end
            if (to_hit) begin
                err_q <= 1'b1;
            end
        end
    end
`else
    logic [31:0] unused_timeout;

    assign unused_timeout = 32'(TIMEOUT);
    assign to_hit         = 1'b0;
    assign err            = 1'b0;
`endif

    always_comb begin
        state_nxt      = state;
        last_grant_nxt = last_grant;
        flushed_nxt    = flushed;
        mem_req_nxt    = bus.mem_req;
        mem_we_nxt     = bus.mem_we;
        mem_addr_nxt   = bus.mem_addr;
        mem_wdata_nxt  = bus.mem_wdata;
        f_ack_nxt      = 1'b0;
        l_ack_nxt      = 1'b0;
        f_rdata_nxt    = bus.f_rdata;
        grant_f        = 1'b0;
        grant_l        = 1'b0;

        case (state)
            IDLE: begin
                grant_f = f_cand && (!l_cand || (last_grant == GNT_LOAD));
                grant_l = l_cand && !grant_f;
                if (grant_f) begin
                    state_nxt      = FETCH;
                    last_grant_nxt = GNT_FETCH;
                    flushed_nxt    = 1'b0;
                    mem_req_nxt    = 1'b1;
                    mem_we_nxt     = 1'b0;
                    mem_addr_nxt   = bus.f_addr;
                    mem_wdata_nxt  = '0;
                end else if (grant_l) begin
                    state_nxt      = LOAD;
                    last_grant_nxt = GNT_LOAD;
                    flushed_nxt    = 1'b0;
                    mem_req_nxt    = 1'b1;
                    mem_we_nxt     = 1'b1;
                    mem_addr_nxt   = bus.l_addr;
                    mem_wdata_nxt  = bus.l_wdata;
                end
            end

            FETCH: begin
                if (bus.f_flush) begin
                    flushed_nxt = 1'b1;
                end
                if (bus.mem_ack || to_hit) begin
                    state_nxt   = IDLE;
                    mem_req_nxt = 1'b0;
                    mem_we_nxt  = 1'b0;
                    // A redirect seen at any point of the cycle discards the word.
                    f_ack_nxt   = !(flushed || bus.f_flush);
                    if (f_ack_nxt) begin
                        f_rdata_nxt = bus.mem_ack ? bus.mem_rdata : NOP;
                    end
                end
            end

            LOAD: begin
                if (bus.mem_ack || to_hit) begin
                    state_nxt   = IDLE;
                    mem_req_nxt = 1'b0;
                    mem_we_nxt  = 1'b0;
                    l_ack_nxt   = 1'b1;
                end
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            last_grant    <= GNT_LOAD;
            flushed       <= 1'b0;
            bus.mem_req   <= 1'b0;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
            bus.f_ack     <= 1'b0;
            bus.l_ack     <= 1'b0;
            bus.f_rdata   <= '0;
        end else begin
            state         <= state_nxt;
            last_grant    <= last_grant_nxt;
            flushed       <= flushed_nxt;
            bus.mem_req   <= mem_req_nxt;
            bus.mem_we    <= mem_we_nxt;
            bus.mem_addr  <= mem_addr_nxt;
            bus.mem_wdata <= mem_wdata_nxt;
            bus.f_ack     <= f_ack_nxt;
            bus.l_ack     <= l_ack_nxt;
            bus.f_rdata   <= f_rdata_nxt;
        end
    end
endmodule

// File: tb/tb_imem_arbiter.sv
// Directed bench for imem_arbiter: reset, contention, fetch, flush, stray ack,
// reset mid-load and the mem_ack watchdog (both builds).
module tb_imem_arbiter;
    logic clk;
    logic rst;
    logic err;
    int   vectors;
    int   miscompares;

    imem_arbiter_if #(.WIDTH(32)) bus ();

    imem_arbiter #(.WIDTH(32), .TIMEOUT(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus),
        .err (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        vectors++; if (bus.mem_req !== 1'b0) begin miscompares++; $display("FAIL rst_mem_req got %b exp 0", bus.mem_req); end
        vectors++; if (bus.mem_we !== 1'b0) begin miscompares++; $display("FAIL rst_mem_we got %b exp 0", bus.mem_we); end
        vectors++; if (bus.f_ack !== 1'b0) begin miscompares++; $display("FAIL rst_f_ack got %b exp 0", bus.f_ack); end
        vectors++; if (bus.l_ack !== 1'b0) begin miscompares++; $display("FAIL rst_l_ack got %b exp 0", bus.l_ack); end
        vectors++; if (err !== 1'b0) begin miscompares++; $display("FAIL rst_err got %b exp 0", err); end
        vectors++; if (bus.mem_addr !== 32'h0) begin miscompares++; $display("FAIL rst_mem_addr got %h exp 0", bus.mem_addr); end
        vectors++; if (bus.mem_wdata !== 32'h0) begin miscompares++; $display("FAIL rst_mem_wdata got %h exp 0", bus.mem_wdata); end
        vectors++; if (bus.f_rdata !== 32'h0) begin miscompares++; $display("FAIL rst_f_rdata got %h exp 0", bus.f_rdata); end
        rst = 1'b0;
    endtask

    task automatic test_contention();
        logic        exp_we;
        logic [31:0] exp_addr;
        bus.f_req   = 1'b1;
        bus.l_req   = 1'b1;
        bus.f_addr  = 32'h0000_0040;
        bus.l_addr  = 32'h0000_0080;
        bus.l_wdata = 32'hA5A5_0000;
        for (int i = 0; i < 4; i++) begin
            int n = 0;
            while (bus.mem_req !== 1'b1 && n < 8) begin
                step();
                n++;
            end
            vectors++; if (bus.mem_req !== 1'b1) begin miscompares++; $display("FAIL cont_grant_wait[%0d] got mem_req %b exp 1", i, bus.mem_req); end
            exp_we   = (i % 2 == 1);
            exp_addr = exp_we ? bus.l_addr : bus.f_addr;
            vectors++; if (bus.mem_we !== exp_we) begin miscompares++; $display("FAIL cont_mem_we[%0d] got %b exp %b", i, bus.mem_we, exp_we); end
            vectors++; if (bus.mem_addr !== exp_addr) begin miscompares++; $display("FAIL cont_mem_addr[%0d] got %h exp %h", i, bus.mem_addr, exp_addr); end
            if (exp_we) begin
                vectors++; if (bus.mem_wdata !== bus.l_wdata) begin miscompares++; $display("FAIL cont_mem_wdata[%0d] got %h exp %h", i, bus.mem_wdata, bus.l_wdata); end
            end
            bus.mem_ack   = 1'b1;
            bus.mem_rdata = 32'h0000_1000 + 32'(i);
            step();
            bus.mem_ack = 1'b0;
            vectors++; if (bus.f_ack !== !exp_we) begin miscompares++; $display("FAIL cont_f_ack[%0d] got %b exp %b", i, bus.f_ack, !exp_we); end
            vectors++; if (bus.l_ack !== exp_we) begin miscompares++; $display("FAIL cont_l_ack[%0d] got %b exp %b", i, bus.l_ack, exp_we); end
            vectors++; if (bus.mem_req !== 1'b0) begin miscompares++; $display("FAIL cont_mem_req_drop[%0d] got %b exp 0", i, bus.mem_req); end
            if (!exp_we) begin
                vectors++; if (bus.f_rdata !== 32'h0000_1000 + 32'(i)) begin miscompares++; $display("FAIL cont_f_rdata[%0d] got %h exp %h", i, bus.f_rdata, 32'h0000_1000 + 32'(i)); end
                bus.f_addr = bus.f_addr + 32'd4;
            end else begin
                bus.l_addr  = bus.l_addr + 32'd4;
                bus.l_wdata = bus.l_wdata + 32'd1;
            end
        end
        bus.f_req = 1'b0;
        bus.l_req = 1'b0;
        step();
        step();
        vectors++; if (bus.mem_req !== 1'b0) begin miscompares++; $display("FAIL cont_idle_after got %b exp 0", bus.mem_req); end
    endtask

    task automatic test_single_fetch();
        bus.f_req  = 1'b1;
        bus.f_addr = 32'h0000_0008;
        #1;
        vectors++; if (bus.stall_if !== 1'b1) begin miscompares++; $display("FAIL fetch_stall_req got %b exp 1", bus.stall_if); end
        step();
        vectors++; if (bus.mem_req !== 1'b1) begin miscompares++; $display("FAIL fetch_mem_req_c1 got %b exp 1", bus.mem_req); end
        vectors++; if (bus.mem_addr !== 32'h0000_0008) begin miscompares++; $display("FAIL fetch_mem_addr got %h exp 00000008", bus.mem_addr); end
        vectors++; if (bus.mem_we !== 1'b0) begin miscompares++; $display("FAIL fetch_mem_we got %b exp 0", bus.mem_we); end
        step();
        vectors++; if (bus.mem_req !== 1'b1) begin miscompares++; $display("FAIL fetch_mem_req_c2 got %b exp 1", bus.mem_req); end
        vectors++; if (bus.f_ack !== 1'b0) begin miscompares++; $display("FAIL fetch_early_ack got %b exp 0", bus.f_ack); end
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 32'h0050_0093;
        step();
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = 32'h0;
        vectors++; if (bus.mem_req !== 1'b0) begin miscompares++; $display("FAIL fetch_mem_req_c3 got %b exp 0", bus.mem_req); end
        vectors++; if (bus.f_ack !== 1'b1) begin miscompares++; $display("FAIL fetch_f_ack got %b exp 1", bus.f_ack); end
        vectors++; if (bus.f_rdata !== 32'h0050_0093) begin miscompares++; $display("FAIL fetch_f_rdata got %h exp 00500093", bus.f_rdata); end
        vectors++; if (bus.stall_if !== 1'b0) begin miscompares++; $display("FAIL fetch_stall_ack got %b exp 0", bus.stall_if); end
        bus.f_req = 1'b0;
        step();
        vectors++; if (bus.f_ack !== 1'b0) begin miscompares++; $display("FAIL fetch_ack_pulse got %b exp 0", bus.f_ack); end
        vectors++; if (bus.mem_req !== 1'b0) begin miscompares++; $display("FAIL fetch_no_regrant got %b exp 0", bus.mem_req); end
    endtask

    task automatic test_flush();
        bus.f_req  = 1'b1;
        bus.f_addr = 32'h0000_0200;
        step();
        vectors++; if (bus.mem_req !== 1'b1) begin miscompares++; $display("FAIL flush_grant got %b exp 1", bus.mem_req); end
        bus.f_flush = 1'b1;
        step();
        bus.f_flush = 1'b0;
        bus.f_addr  = 32'h0000_0300;
        step();
        vectors++; if (bus.mem_addr !== 32'h0000_0200) begin miscompares++; $display("FAIL flush_addr_held got %h exp 00000200", bus.mem_addr); end
        step();
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 32'hDEAD_BEEF;
        step();
        bus.mem_ack = 1'b0;
        vectors++; if (bus.f_ack !== 1'b0) begin miscompares++; $display("FAIL flush_no_ack got %b exp 0", bus.f_ack); end
        vectors++; if (bus.mem_req !== 1'b0) begin miscompares++; $display("FAIL flush_mem_req got %b exp 0", bus.mem_req); end
        vectors++; if (bus.f_rdata !== 32'h0050_0093) begin miscompares++; $display("FAIL flush_rdata_kept got %h exp 00500093", bus.f_rdata); end
        #1;
        vectors++; if (bus.stall_if !== 1'b1) begin miscompares++; $display("FAIL flush_stall got %b exp 1", bus.stall_if); end
        step();
        vectors++; if (bus.mem_req !== 1'b1) begin miscompares++; $display("FAIL flush_next_grant got %b exp 1", bus.mem_req); end
        vectors++; if (bus.mem_addr !== 32'h0000_0300) begin miscompares++; $display("FAIL flush_next_addr got %h exp 00000300", bus.mem_addr); end
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 32'h0000_0513;
        step();
        bus.mem_ack = 1'b0;
        vectors++; if (bus.f_ack !== 1'b1) begin miscompares++; $display("FAIL flush_next_ack got %b exp 1", bus.f_ack); end
        vectors++; if (bus.f_rdata !== 32'h0000_0513) begin miscompares++; $display("FAIL flush_next_rdata got %h exp 00000513", bus.f_rdata); end
        bus.f_req = 1'b0;
        step();
    endtask

    task automatic test_stray_ack();
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 32'hFFFF_FFFF;
        step();
        bus.mem_ack = 1'b0;
        vectors++; if (bus.f_ack !== 1'b0) begin miscompares++; $display("FAIL stray_f_ack got %b exp 0", bus.f_ack); end
        vectors++; if (bus.l_ack !== 1'b0) begin miscompares++; $display("FAIL stray_l_ack got %b exp 0", bus.l_ack); end
        vectors++; if (bus.mem_req !== 1'b0) begin miscompares++; $display("FAIL stray_mem_req got %b exp 0", bus.mem_req); end
        step();
        vectors++; if (bus.f_rdata !== 32'h0000_0513) begin miscompares++; $display("FAIL stray_rdata got %h exp 00000513", bus.f_rdata); end
    endtask

    task automatic test_reset_mid_load();
        bus.l_req   = 1'b1;
        bus.l_addr  = 32'h0000_0044;
        bus.l_wdata = 32'h0000_1234;
        step();
        vectors++; if (bus.mem_we !== 1'b1) begin miscompares++; $display("FAIL rml_mem_we got %b exp 1", bus.mem_we); end
        step();
        rst = 1'b1;
        step();
        vectors++; if (bus.mem_req !== 1'b0) begin miscompares++; $display("FAIL rml_mem_req got %b exp 0", bus.mem_req); end
        vectors++; if (bus.l_ack !== 1'b0) begin miscompares++; $display("FAIL rml_l_ack got %b exp 0", bus.l_ack); end
        rst        = 1'b0;
        bus.f_req  = 1'b1;
        bus.f_addr = 32'h0000_0060;
        step();
        vectors++; if (bus.mem_we !== 1'b0) begin miscompares++; $display("FAIL rml_fetch_first_we got %b exp 0", bus.mem_we); end
        vectors++; if (bus.mem_addr !== 32'h0000_0060) begin miscompares++; $display("FAIL rml_fetch_first_addr got %h exp 00000060", bus.mem_addr); end
        vectors++; if (bus.l_ack !== 1'b0) begin miscompares++; $display("FAIL rml_late_l_ack got %b exp 0", bus.l_ack); end
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 32'h0000_0073;
        step();
        bus.mem_ack = 1'b0;
        vectors++; if (bus.f_ack !== 1'b1) begin miscompares++; $display("FAIL rml_f_ack got %b exp 1", bus.f_ack); end
        bus.f_req = 1'b0;
        step();
        vectors++; if (bus.mem_we !== 1'b1) begin miscompares++; $display("FAIL rml_load_we got %b exp 1", bus.mem_we); end
        vectors++; if (bus.mem_wdata !== 32'h0000_1234) begin miscompares++; $display("FAIL rml_load_wdata got %h exp 00001234", bus.mem_wdata); end
        bus.mem_ack = 1'b1;
        step();
        bus.mem_ack = 1'b0;
        vectors++; if (bus.l_ack !== 1'b1) begin miscompares++; $display("FAIL rml_l_ack_done got %b exp 1", bus.l_ack); end
        vectors++; if (bus.f_ack !== 1'b0) begin miscompares++; $display("FAIL rml_no_f_ack got %b exp 0", bus.f_ack); end
        bus.l_req = 1'b0;
        step();
    endtask

    task automatic test_timeout();
        bus.f_req  = 1'b1;
        bus.f_addr = 32'h0000_0400;
        step();
`ifdef IMEM_ARB_TIMEOUT_EN
        for (int k = 0; k < 4; k++) begin
            vectors++; if (bus.mem_req !== 1'b1) begin miscompares++; $display("FAIL to_mem_req[%0d] got %b exp 1", k, bus.mem_req); end
            step();
        end
        vectors++; if (bus.mem_req !== 1'b0) begin miscompares++; $display("FAIL to_mem_req_drop got %b exp 0", bus.mem_req); end
        vectors++; if (bus.f_ack !== 1'b1) begin miscompares++; $display("FAIL to_f_ack got %b exp 1", bus.f_ack); end
        vectors++; if (bus.f_rdata !== 32'h0000_0013) begin miscompares++; $display("FAIL to_f_rdata got %h exp 00000013", bus.f_rdata); end
        vectors++; if (err !== 1'b1) begin miscompares++; $display("FAIL to_err got %b exp 1", err); end
        bus.f_req = 1'b0;
        step();
        step();
        vectors++; if (err !== 1'b1) begin miscompares++; $display("FAIL to_err_sticky got %b exp 1", err); end
        vectors++; if (bus.f_ack !== 1'b0) begin miscompares++; $display("FAIL to_ack_pulse got %b exp 0", bus.f_ack); end
`else
        for (int k = 0; k < 20; k++) begin
            vectors++; if (bus.mem_req !== 1'b1) begin miscompares++; $display("FAIL wait_mem_req[%0d] got %b exp 1", k, bus.mem_req); end
            vectors++; if (err !== 1'b0) begin miscompares++; $display("FAIL wait_err[%0d] got %b exp 0", k, err); end
            step();
        end
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 32'h0000_ABCD;
        step();
        bus.mem_ack = 1'b0;
        vectors++; if (bus.f_ack !== 1'b1) begin miscompares++; $display("FAIL wait_f_ack got %b exp 1", bus.f_ack); end
        vectors++; if (bus.f_rdata !== 32'h0000_ABCD) begin miscompares++; $display("FAIL wait_f_rdata got %h exp 0000abcd", bus.f_rdata); end
        vectors++; if (err !== 1'b0) begin miscompares++; $display("FAIL wait_err_end got %b exp 0", err); end
        bus.f_req = 1'b0;
        step();
`endif
    endtask

    initial begin
        vectors       = 0;
        miscompares   = 0;
        rst           = 1'b1;
        bus.f_req     = 1'b0;
        bus.f_addr    = '0;
        bus.f_flush   = 1'b0;
        bus.l_req     = 1'b0;
        bus.l_addr    = '0;
        bus.l_wdata   = '0;
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = '0;
        test_reset();
        test_contention();
        test_single_fetch();
        test_flush();
        test_stray_ack();
        test_reset_mid_load();
        test_timeout();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, vectors %0d", vectors);
        $fatal(1, "time limit");
    end
endmodule

// File: doc/imem_arbiter.md
IMEM_ARBITER -- requirements
Module: imem_arbiter

Interface
REQ-001 Parameter WIDTH, default 32: address and PC width in bits.
REQ-002 Parameter TIMEOUT, default 15: the maximum number of cycles mem_req may wait for mem_ack; legal range 1..255.
REQ-003 clk  input  1: clock; all state SHALL update on the rising edge.
REQ-004 rst  input  1: reset, synchronous, active-high.
REQ-005 f_req  input  1: fetch request from the IF stage; held high until f_ack or f_flush.
REQ-006 f_addr  input  WIDTH: fetch byte address; sampled at grant.
REQ-007 f_flush  input  1: IF redirect (taken branch); cancels any outstanding fetch.
REQ-008 f_ack  output  1: one-cycle pulse; f_rdata is valid in that cycle.
REQ-009 f_rdata  output  32: fetched instruction word.
REQ-010 l_req  input  1: program-loader write request; held high until l_ack.
REQ-011 l_addr, l_wdata  input  WIDTH, 32: loader write address and data; sampled at grant.
REQ-012 l_ack  output  1: one-cycle pulse marking loader write completion.
REQ-013 mem_req, mem_we  output  1, 1: request and write-enable to the single-port instruction memory.
REQ-014 mem_addr, mem_wdata  output  WIDTH, 32: memory address and write data.
REQ-015 mem_ack, mem_rdata  input  1, 32: memory completion pulse and read data; mem_rdata is valid with mem_ack.
REQ-016 stall_if  output  1: high whenever f_req is high and f_ack is low; IF SHALL hold its PC while it is high.
REQ-017 err  output  1: sticky timeout flag.

Function
REQ-018 The FSM SHALL have exactly three states: IDLE, FETCH, LOAD.
REQ-019 In IDLE with exactly one of f_req and l_req high, the arbiter SHALL enter the matching state on the next edge.
REQ-020 In IDLE with f_req and l_req both high, the arbiter SHALL grant the requester not granted last (round-robin); the last_grant register SHALL reset to LOAD so that fetch wins first.
REQ-021 In IDLE with f_flush high, f_req SHALL be ignored for arbitration in that cycle.
REQ-022 On entry to FETCH or LOAD, the arbiter SHALL register mem_req=1, mem_addr, mem_wdata, and mem_we (1 for LOAD only) and hold them constant until mem_ack.
REQ-023 When mem_ack is seen in cycle M, the arbiter SHALL deassert mem_req at M+1, pulse f_ack (with registered f_rdata) or l_ack at M+1, and return to IDLE at M+1; the minimum request-to-next-mem_req spacing is 2 cycles.
REQ-024 When f_flush is asserted while in FETCH, the transaction SHALL still run to mem_ack, but f_ack SHALL be suppressed and the data discarded.
REQ-025 f_flush SHALL have no effect on a LOAD transaction.
REQ-026 mem_ack received in IDLE SHALL be ignored.
REQ-027 A requester dropping its req mid-transaction SHALL NOT abort the memory cycle; its ack SHALL still be pulsed.
REQ-028 f_ack and l_ack SHALL never be high in the same cycle.

Reset
REQ-029 On rst, the arbiter SHALL set state=IDLE, mem_req=0, mem_we=0, f_ack=0, l_ack=0, err=0, timeout counter=0, and last_grant=LOAD, with mem_addr, mem_wdata, and f_rdata all 0.
REQ-030 rst asserted mid-transaction SHALL abandon the transaction with no ack pulsed; mem_req SHALL be 0 in the cycle after the reset edge.

Configuration
REQ-031 Macro IMEM_ARB_TIMEOUT_EN controls the timeout watchdog.
- Defined: an 8-bit counter SHALL count cycles while mem_req is high and clear on each new grant.
- When the counter reaches TIMEOUT without mem_ack, the arbiter SHALL deassert mem_req, set err (cleared only by rst), pulse the pending ack with f_rdata=32'h00000013 (NOP) for a fetch, and return to IDLE, all on the next edge.
- Undefined: there SHALL be no counter, err SHALL be tied to 0, and the arbiter SHALL wait for mem_ack indefinitely.

Verification
REQ-032 Single fetch: f_req=1, f_addr=0x8, mem_ack after 2 cycles with rdata 0x00500093 -> mem_req high 2 cycles, f_ack one cycle with f_rdata=0x00500093, stall_if low from the f_ack cycle.
REQ-033 Contention: f_req and l_req held high continuously -> grants alternate F,L,F,L; l_ack transactions drive mem_we=1 with the correct l_addr and l_wdata.
REQ-034 Flush: f_flush pulsed one cycle into FETCH, mem_ack 3 cycles later -> no f_ack, arbiter back in IDLE, the next fetch proceeds normally.
REQ-035 Reset mid-LOAD: rst asserted while mem_req=1 -> mem_req=0 on the next cycle, no l_ack, fetch granted first afterwards.
REQ-036 Timeout (IMEM_ARB_TIMEOUT_EN defined, TIMEOUT=4): mem_ack never returned -> mem_req drops after 4 cycles, err=1 and held, f_ack with f_rdata=0x00000013.
REQ-037 Stray ack: mem_ack pulsed in IDLE -> no f_ack, no l_ack, no state change.
